// File: rtl/h_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : h_pkg (package)
//  Description : Shared types and defaults for the set-associative key/value
//                table: command opcodes, response status codes, default
//                key/value widths and a small width helper.
//  Contents    : opcode_t   NOP=0 QRY=1 INS=2 DEL=3 CLR=4 (5..7 act as NOP)
//                status_t   OK=0 HIT=1 MISS=2 FULL=3 EVICT=4
//                c_k_w_dflt / c_v_w_dflt default widths
//                clog2_min1() index width that never collapses to zero
//  Revision    : 1.0 - initial release
// ============================================================================
package h_pkg;

    localparam int c_k_w_dflt = 32;
    localparam int c_v_w_dflt = 32;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_QRY = 3'd1,
        OP_INS = 3'd2,
        OP_DEL = 3'd3,
        OP_CLR = 3'd4
    } opcode_t;

    typedef enum logic [2:0] {
        ST_OK    = 3'd0,
        ST_HIT   = 3'd1,
        ST_MISS  = 3'd2,
        ST_FULL  = 3'd3,
        ST_EVICT = 3'd4
    } status_t;

    // A single-way set still needs a 1-bit way index signal.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/h_assoc_set.sv
`default_nettype none
// ============================================================================
//  Module      : h_assoc_set
//  Description : Lookup logic for one set. Compares the command key against
//                every valid way and reports hit, the hit way (lowest index
//                wins on a multi-match), whether the set is full and the
//                lowest-index free way. Purely combinational.
//  Ports       : i_way_k    [WAYS_N] keys stored in the set
//                i_way_vld  valid bit per way
//                i_key      command key
//                o_hit      some valid way holds i_key
//                o_hit_way  index of the matching way
//                o_full     every way valid
//                o_free_way lowest-index invalid way
//  Revision    : 1.0 - initial release
// ============================================================================
module h_assoc_set
    import h_pkg::*;
#(
    parameter int K_W    = c_k_w_dflt,
    parameter int WAYS_N = 4,
    parameter int WAY_W  = clog2_min1(WAYS_N)
) (
    input  logic [K_W-1:0]    i_way_k [WAYS_N],
    input  logic [WAYS_N-1:0] i_way_vld,
    input  logic [K_W-1:0]    i_key,
    output logic              o_hit,
    output logic [WAY_W-1:0]  o_hit_way,
    output logic              o_full,
    output logic [WAY_W-1:0]  o_free_way
);

    logic [WAYS_N-1:0] w_hit_vec;

    genvar g;
    generate
        for (g = 0; g < WAYS_N; g++) begin : g_cmp
            assign w_hit_vec[g] = i_way_vld[g] && (i_way_k[g] == i_key);
        end
    endgenerate

    // Scan from the top down so the lowest matching / free index is the one
    // left standing.
    always_comb begin
        o_hit_way  = '0;
        o_free_way = '0;
        for (int i = WAYS_N - 1; i >= 0; i--) begin
            if (w_hit_vec[i]) begin
                o_hit_way = WAY_W'(i);
            end
            if (!i_way_vld[i]) begin
                o_free_way = WAY_W'(i);
            end
        end
    end

    assign o_hit  = |w_hit_vec;
    assign o_full = &i_way_vld;

endmodule
`default_nettype wire

// File: rtl/h_assoc.sv
`default_nettype none
// ============================================================================
//  Module      : h_assoc
//  Description : Parametrised set-associative key/value table with a
//                valid/ready command port and one registered response per
//                QRY/INS/DEL/CLR command. An XOR fold of the key selects the
//                set; CLR sweeps one set per cycle while holding off commands.
//  Ports       : clk, arst_n (async active-low)
//                cmd_vld/cmd_rdy/cmd_opcode/cmd_k/cmd_v  command channel
//                rsp_vld/rsp_status/rsp_v               response (no stall)
//  Config      : H_ASSOC_EVICT_EN - when defined, INS into a full set evicts
//                the way named by a per-set round-robin pointer and returns
//                EVICT; otherwise FULL is returned and the table is unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module h_assoc
    import h_pkg::*;
#(
    parameter int K_W    = c_k_w_dflt,
    parameter int V_W    = c_v_w_dflt,
    parameter int SETS_N = 16,
    parameter int WAYS_N = 4
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic           cmd_vld,
    output logic           cmd_rdy,
    input  opcode_t        cmd_opcode,
    input  logic [K_W-1:0] cmd_k,
    input  logic [V_W-1:0] cmd_v,
    output logic           rsp_vld,
    output status_t        rsp_status,
    output logic [V_W-1:0] rsp_v
);

    localparam int c_idx_w    = $clog2(SETS_N);
    localparam int c_way_w    = clog2_min1(WAYS_N);
    localparam int c_chunks   = (K_W + c_idx_w - 1) / c_idx_w;
    localparam logic [c_idx_w-1:0] c_last_set = c_idx_w'(SETS_N - 1);

    localparam logic [0:0] c_fsm_idle  = 1'b0;
    localparam logic [0:0] c_fsm_sweep = 1'b1;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [K_W-1:0]    r_key [SETS_N][WAYS_N];
    logic [V_W-1:0]    r_val [SETS_N][WAYS_N];
    logic [WAYS_N-1:0] r_vld [SETS_N];

    logic [0:0]         r_state;
    logic [c_idx_w-1:0] r_cnt;
    logic               r_cmd_rdy;
    logic               r_rsp_vld;
    status_t            r_rsp_status;
    logic [V_W-1:0]     r_rsp_v;

    // ------------------------------------------------------------------
    // Hash: XOR of the key cut into index-wide chunks, top chunk
    // zero-padded.
    // ------------------------------------------------------------------
    logic [c_chunks*c_idx_w-1:0] w_key_pad;
    logic [c_idx_w-1:0]          w_idx;

    always_comb begin
        w_key_pad          = '0;
        w_key_pad[K_W-1:0] = cmd_k;
        w_idx              = '0;
        for (int i = 0; i < c_chunks; i++) begin
            w_idx = w_idx ^ w_key_pad[i*c_idx_w +: c_idx_w];
        end
    end

    // ------------------------------------------------------------------
    // Read of the addressed set and per-set lookup
    // ------------------------------------------------------------------
    logic [K_W-1:0]    w_set_k [WAYS_N];
    logic [V_W-1:0]    w_set_v [WAYS_N];
    logic [WAYS_N-1:0] w_set_vld;
    logic              w_hit;
    logic              w_full;
    logic [c_way_w-1:0] w_hit_way;
    logic [c_way_w-1:0] w_free_way;

    always_comb begin
        for (int w = 0; w < WAYS_N; w++) begin
            w_set_k[w] = r_key[w_idx][w];
            w_set_v[w] = r_val[w_idx][w];
        end
        w_set_vld = r_vld[w_idx];
    end

    h_assoc_set #(
        .K_W    (K_W),
        .WAYS_N (WAYS_N),
        .WAY_W  (c_way_w)
    ) u_set (
        .i_way_k    (w_set_k),
        .i_way_vld  (w_set_vld),
        .i_key      (cmd_k),
        .o_hit      (w_hit),
        .o_hit_way  (w_hit_way),
        .o_full     (w_full),
        .o_free_way (w_free_way)
    );

`ifdef H_ASSOC_EVICT_EN
    logic [c_way_w-1:0] r_rr [SETS_N];
    logic [c_way_w-1:0] w_rr_way;
    logic               w_evict;

    assign w_rr_way = r_rr[w_idx];
`endif

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic               w_acc;
    logic               w_rsp_en;
    status_t            w_rsp_status;
    logic [V_W-1:0]     w_rsp_v;
    logic               w_wr_en;
    logic [c_way_w-1:0] w_wr_way;
    logic               w_del;
    logic               w_clr_start;

    assign w_acc = cmd_vld && r_cmd_rdy;

    always_comb begin
        w_rsp_en     = 1'b0;
        w_rsp_status = ST_OK;
        w_rsp_v      = '0;
        w_wr_en      = 1'b0;
        w_wr_way     = '0;
        w_del        = 1'b0;
        w_clr_start  = 1'b0;
`ifdef H_ASSOC_EVICT_EN
        w_evict      = 1'b0;
`endif
        if (w_acc) begin
            case (cmd_opcode)
                OP_QRY: begin
                    w_rsp_en = 1'b1;
                    if (w_hit) begin
                        w_rsp_status = ST_HIT;
                        w_rsp_v      = w_set_v[w_hit_way];
                    end else begin
                        w_rsp_status = ST_MISS;
                    end
                end
                OP_INS: begin
                    w_rsp_en = 1'b1;
                    if (w_hit) begin
                        w_wr_en      = 1'b1;
                        w_wr_way     = w_hit_way;
                        w_rsp_status = ST_HIT;
                        w_rsp_v      = w_set_v[w_hit_way];
                    end else if (!w_full) begin
                        w_wr_en      = 1'b1;
                        w_wr_way     = w_free_way;
                        w_rsp_status = ST_OK;
                    end else begin
`ifdef H_ASSOC_EVICT_EN
                        w_wr_en      = 1'b1;
                        w_wr_way     = w_rr_way;
                        w_evict      = 1'b1;
                        w_rsp_status = ST_EVICT;
                        w_rsp_v      = w_set_v[w_rr_way];
`else
                        w_rsp_status = ST_FULL;
`endif
                    end
                end
                OP_DEL: begin
                    w_rsp_en = 1'b1;
                    if (w_hit) begin
                        w_del        = 1'b1;
                        w_rsp_status = ST_HIT;
                        w_rsp_v      = w_set_v[w_hit_way];
                    end else begin
                        w_rsp_status = ST_MISS;
                    end
                end
                OP_CLR: begin
                    w_clr_start = 1'b1;
                end
                default: begin
                    // NOP and undefined opcodes: accepted silently.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Key/value payload: no reset needed, validity lives in r_vld.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_key[w_idx][w_wr_way] <= cmd_k;
            r_val[w_idx][w_wr_way] <= cmd_v;
        end
    end

    // ------------------------------------------------------------------
    // Valid bits. Commands are held off during a sweep, so the sweep clear
    // never collides with a command write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int s = 0; s < SETS_N; s++) begin
                r_vld[s] <= '0;
            end
        end else if (r_state == c_fsm_sweep) begin
            r_vld[r_cnt] <= '0;
        end else begin
            if (w_wr_en) begin
                r_vld[w_idx][w_wr_way] <= 1'b1;
            end
            if (w_del) begin
                r_vld[w_idx][w_hit_way] <= 1'b0;
            end
        end
    end

`ifdef H_ASSOC_EVICT_EN
    // Round-robin victim pointer per set; moves only when a victim is taken.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int s = 0; s < SETS_N; s++) begin
                r_rr[s] <= '0;
            end
        end else if (w_evict) begin
            r_rr[w_idx] <= (w_rr_way == c_way_w'(WAYS_N - 1)) ? '0
                                                               : w_rr_way + c_way_w'(1);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Control FSM, sweep counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= c_fsm_idle;
            r_cnt        <= '0;
            r_cmd_rdy    <= 1'b1;
            r_rsp_vld    <= 1'b0;
            r_rsp_status <= ST_OK;
            r_rsp_v      <= '0;
        end else begin
            r_rsp_vld <= 1'b0;
            case (r_state)
                c_fsm_idle: begin
                    if (w_clr_start) begin
                        r_state   <= c_fsm_sweep;
                        r_cnt     <= '0;
                        r_cmd_rdy <= 1'b0;
                    end else if (w_rsp_en) begin
                        r_rsp_vld    <= 1'b1;
                        r_rsp_status <= w_rsp_status;
                        r_rsp_v      <= w_rsp_v;
                    end
                end
                c_fsm_sweep: begin
                    if (r_cnt == c_last_set) begin
                        r_state      <= c_fsm_idle;
                        r_cnt        <= '0;
                        r_cmd_rdy    <= 1'b1;
                        r_rsp_vld    <= 1'b1;
                        r_rsp_status <= ST_OK;
                        r_rsp_v      <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_idx_w'(1);
                    end
                end
                default: begin
                    r_state   <= c_fsm_idle;
                    r_cmd_rdy <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_rdy    = r_cmd_rdy;
    assign rsp_vld    = r_rsp_vld;
    assign rsp_status = r_rsp_status;
    assign rsp_v      = r_rsp_v;

endmodule
`default_nettype wire

// File: tb/tb_h_assoc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_h_assoc
//  Description : Self-checking bench for h_assoc (16 sets x 4 ways, 32-bit
//                key/value). A behavioural table model produces the expected
//                response for every accepted command into a queue; a monitor
//                pops and compares each DUT response.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_h_assoc;
    import h_pkg::*;

    localparam int c_sets = 16;
    localparam int c_ways = 4;

    logic           clk = 1'b0;
    logic           arst_n;
    logic           cmd_vld;
    logic           cmd_rdy;
    opcode_t        cmd_opcode;
    logic [31:0]    cmd_k;
    logic [31:0]    cmd_v;
    logic           rsp_vld;
    status_t        rsp_status;
    logic [31:0]    rsp_v;

    always #5 clk = ~clk;

    h_assoc #(
        .K_W    (32),
        .V_W    (32),
        .SETS_N (c_sets),
        .WAYS_N (c_ways)
    ) u_dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .cmd_vld    (cmd_vld),
        .cmd_rdy    (cmd_rdy),
        .cmd_opcode (cmd_opcode),
        .cmd_k      (cmd_k),
        .cmd_v      (cmd_v),
        .rsp_vld    (rsp_vld),
        .rsp_status (rsp_status),
        .rsp_v      (rsp_v)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        status_t     st;
        logic [31:0] v;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_key [c_sets][c_ways];
    logic [31:0] m_val [c_sets][c_ways];
    bit   [3:0]  m_vld [c_sets];
    int          m_rr  [c_sets];

    function automatic int hash(input logic [31:0] k);
        logic [3:0] h;
        h = 4'h0;
        for (int i = 0; i < 8; i++) h = h ^ k[i*4 +: 4];
        return int'(h);
    endfunction

    task automatic push(input status_t st, input logic [31:0] v, input string tag);
        exp_t e;
        e.st  = st;
        e.v   = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        for (int s = 0; s < c_sets; s++) begin
            m_vld[s] = '0;
            m_rr[s]  = 0;
        end
    endtask

    task automatic model(input opcode_t op, input logic [31:0] k, input logic [31:0] v);
        int s, hw, ff;
        s  = hash(k);
        hw = -1;
        ff = -1;
        for (int w = c_ways - 1; w >= 0; w--) begin
            if (m_vld[s][w] && m_key[s][w] == k) hw = w;
            if (!m_vld[s][w]) ff = w;
        end
        case (op)
            OP_QRY: begin
                if (hw >= 0) push(ST_HIT, m_val[s][hw], "qry");
                else         push(ST_MISS, 32'h0, "qry");
            end
            OP_INS: begin
                if (hw >= 0) begin
                    push(ST_HIT, m_val[s][hw], "ins");
                    m_val[s][hw] = v;
                end else if (ff >= 0) begin
                    push(ST_OK, 32'h0, "ins");
                    m_vld[s][ff] = 1'b1;
                    m_key[s][ff] = k;
                    m_val[s][ff] = v;
                end else begin
`ifdef H_ASSOC_EVICT_EN
                    push(ST_EVICT, m_val[s][m_rr[s]], "ins");
                    m_key[s][m_rr[s]] = k;
                    m_val[s][m_rr[s]] = v;
                    m_rr[s] = (m_rr[s] + 1) % c_ways;
`else
                    push(ST_FULL, 32'h0, "ins");
`endif
                end
            end
            OP_DEL: begin
                if (hw >= 0) begin
                    push(ST_HIT, m_val[s][hw], "del");
                    m_vld[s][hw] = 1'b0;
                end else begin
                    push(ST_MISS, 32'h0, "del");
                end
            end
            OP_CLR: begin
                for (int i = 0; i < c_sets; i++) m_vld[i] = '0;
                push(ST_OK, 32'h0, "clr");
            end
            default: ;
        endcase
    endtask

    // Response monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (arst_n === 1'b1 && rsp_vld === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_status"}, 64'(rsp_status), 64'(e.st));
                chk({e.tag, "_value"}, 64'(rsp_v), 64'(e.v));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic issue(input opcode_t op, input logic [31:0] k, input logic [31:0] v,
                         output int waits);
        @(negedge clk);
        cmd_vld    = 1'b1;
        cmd_opcode = op;
        cmd_k      = k;
        cmd_v      = v;
        waits      = 0;
        while (!cmd_rdy && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (!cmd_rdy) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else begin
            model(op, k, v);
        end
        @(posedge clk);
    endtask

    task automatic go(input opcode_t op, input logic [31:0] k, input logic [31:0] v);
        int waits;
        issue(op, k, v, waits);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        cmd_vld    = 1'b0;
        cmd_opcode = OP_NOP;
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int         waits;
        logic [31:0] pool [8];
        pool = '{32'h00, 32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h01, 32'h10};

        arst_n     = 1'b0;
        cmd_vld    = 1'b0;
        cmd_opcode = OP_NOP;
        cmd_k      = '0;
        cmd_v      = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
        chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
        chk("rst_rsp_status", 64'(rsp_status), 64'(ST_OK));
        chk("rst_rsp_v", 64'(rsp_v), 64'd0);
        arst_n = 1'b1;
        idle(1);

        // Basic query / insert / overwrite
        go(OP_QRY, 32'h10, 32'h0);
        go(OP_INS, 32'h10, 32'hAA);
        go(OP_QRY, 32'h10, 32'h0);
        go(OP_INS, 32'h10, 32'hBB);
        go(OP_QRY, 32'h10, 32'h0);

        // Fill set 0 (these keys all fold to index 0), then overflow it
        go(OP_INS, 32'h00, 32'hA000);
        go(OP_INS, 32'h11, 32'hA011);
        go(OP_INS, 32'h22, 32'hA022);
        go(OP_INS, 32'h33, 32'hA033);
        go(OP_INS, 32'h44, 32'hA044);
        go(OP_QRY, 32'h00, 32'h0);

        // Delete, re-delete, refill freed way, set full again
        go(OP_DEL, 32'h22, 32'h0);
        go(OP_DEL, 32'h22, 32'h0);
        go(OP_INS, 32'h44, 32'hB044);
        go(OP_QRY, 32'h44, 32'h0);
        go(OP_INS, 32'h55, 32'hA055);

        // NOP and undefined opcodes produce nothing
        go(OP_NOP, 32'h11, 32'h0);
        go(opcode_t'(3'd5), 32'h11, 32'h0);
        go(opcode_t'(3'd7), 32'h11, 32'h0);
        go(OP_QRY, 32'h11, 32'h0);
        idle(2);

        // Back-to-back mixed traffic on two sets
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2:    go(OP_QRY, pool[$urandom_range(0, 7)], 32'h0);
                3, 4, 5, 6: go(OP_INS, pool[$urandom_range(0, 7)], $urandom);
                7, 8:       go(OP_DEL, pool[$urandom_range(0, 7)], 32'h0);
                default:    go(OP_NOP, pool[$urandom_range(0, 7)], 32'h0);
            endcase
        end

        // CLR with cmd_vld held high: a QRY waits behind the sweep
        go(OP_INS, 32'hF0, 32'hCAFE);
        issue(OP_CLR, 32'h0, 32'h0, waits);
        issue(OP_QRY, 32'h11, 32'h0, waits);
        chk("clr_rdy_low_cycles", 64'(waits), 64'd16);
        go(OP_QRY, 32'h10, 32'h0);
        go(OP_QRY, 32'h00, 32'h0);
        go(OP_QRY, 32'hF0, 32'h0);
        go(OP_QRY, 32'h44, 32'h0);
        idle(2);

        // Reset in the middle of a sweep
        go(OP_INS, 32'hF0, 32'h1234);
        go(OP_INS, 32'h33, 32'h5678);
        issue(OP_CLR, 32'h0, 32'h0, waits);
        idle(4);
        arst_n = 1'b0;
        sb.delete();
        model_reset();
        #1;
        chk("midsweep_rst_rsp_vld", 64'(rsp_vld), 64'd0);
        chk("midsweep_rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        repeat (SETS_WAIT()) @(negedge clk);
        chk("post_rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
        chk("post_rst_no_rsp", 64'(sb.size()), 64'd0);
        go(OP_QRY, 32'hF0, 32'h0);
        go(OP_QRY, 32'h33, 32'h0);
        go(OP_INS, 32'h33, 32'h9999);
        go(OP_QRY, 32'h33, 32'h0);

        idle(4);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Long enough for an aborted sweep to have finished had it survived reset.
    function automatic int SETS_WAIT();
        return c_sets + 4;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, required finish before timeout");
        $fatal(1);
    end

endmodule
`default_nettype wire
